// File: rtl/poly_eval_core.sv
// Horner polynomial evaluator fed by FWFT instruction/data FIFOs.
// Build option SATURATE_EN: clamp each step on overflow instead of wrapping.
module poly_eval_core #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int DEG_W      = 4,
  parameter int MAX_DEGREE = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              empty_instruction,
  input  logic [DEG_W+1:0]  instruction,
  output logic              read_enable_instruction,
  input  logic              empty_data,
  input  logic [DATA_W-1:0] data,
  output logic              read_enable_data,
  input  logic              full_result,
  output logic [ACC_W-1:0]  result,
  output logic              write_enable_result,
  input  logic              full_status,
  output logic [7:0]        status,
  output logic              write_enable_status,
  output logic              busy
);

  localparam int PW = ACC_W + DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE, LOAD_X, ACCUM, WRITE
  } state_t;

  state_t                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  x_q;
  logic        [DEG_W-1:0]   deg_q;
  logic        [DEG_W-1:0]   cnt_q;
  logic                      ovf_q;
  logic        [5:0]         seq_q;
  logic        [ACC_W-1:0]   result_q;
  logic        [7:0]         status_q;
  logic                      we_q;

  logic [1:0]               op;
  logic [DEG_W-1:0]         deg;
  logic                     illegal;
  logic signed [PW-1:0]     acc_ext;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     c_ext;
  logic signed [PW-1:0]     exact;
  logic [PW-ACC_W:0]        hi;
  logic                     step_ovf;
  logic                     ovf_d;
  logic [ACC_W-1:0]         acc_d;

  assign op      = instruction[DEG_W+1:DEG_W];
  assign deg     = instruction[DEG_W-1:0];
  assign illegal = (op == 2'b11) || (int'(deg) > MAX_DEGREE);

  // Exact step value; upper bits must all match the ACC_W sign bit.
  assign acc_ext  = {{(DATA_W+1){acc_q[ACC_W-1]}}, acc_q};
  assign x_ext    = {{(ACC_W+1){x_q[DATA_W-1]}}, x_q};
  assign c_ext    = {{(ACC_W+1){data[DATA_W-1]}}, data};
  assign exact    = acc_ext * x_ext + c_ext;
  assign hi       = exact[PW-1:ACC_W-1];
  assign step_ovf = !((&hi) || !(|hi));
  assign ovf_d    = ovf_q | step_ovf;

`ifdef SATURATE_EN
  always_comb begin
    acc_d = exact[ACC_W-1:0];
    if (step_ovf)
      acc_d = exact[PW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                          : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_d = exact[ACC_W-1:0];
`endif

  assign read_enable_instruction =
    !reset && (state_q == IDLE) && !empty_instruction;
  assign read_enable_data =
    !reset && !empty_data &&
    ((state_q == LOAD_X) || (state_q == ACCUM));

  assign write_enable_result = we_q;
  assign write_enable_status = we_q;
  assign result              = result_q;
  assign status              = status_q;
  assign busy                = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      deg_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= '0;
      result_q <= '0;
      status_q <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty_instruction) begin
            deg_q <= deg;
            cnt_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            if (illegal) begin
              result_q <= '0;
              status_q <= {1'b0, 1'b1, seq_q};
              state_q  <= WRITE;
            end else if (op == 2'b00) begin
              state_q <= LOAD_X;
            end else if (op == 2'b01) begin
              x_q     <= DATA_W'(1);
              state_q <= ACCUM;
            end
          end
        end
        LOAD_X: begin
          if (!empty_data) begin
            x_q     <= data;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (!empty_data) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (cnt_q == deg_q) begin
              result_q <= acc_d;
              status_q <= {ovf_d, 1'b0, seq_q};
              state_q  <= WRITE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (!full_result && !full_status) begin
            we_q    <= 1'b1;
            seq_q   <= seq_q + 6'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_core.sv
// Directed bench for poly_eval_core with FWFT FIFO models.
// Expected values are hand-computed per step.
module tb_poly_eval_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        empty_instruction;
  logic [5:0]  instruction;
  logic        read_enable_instruction;
  logic        empty_data;
  logic [15:0] data;
  logic        read_enable_data;
  logic        full_result;
  logic [31:0] result;
  logic        write_enable_result;
  logic        full_status;
  logic [7:0]  status;
  logic        write_enable_status;
  logic        busy;

  poly_eval_core #(
    .DATA_W(16), .ACC_W(32), .DEG_W(4), .MAX_DEGREE(14)
  ) dut (
    .clock(clock),
    .reset(reset),
    .empty_instruction(empty_instruction),
    .instruction(instruction),
    .read_enable_instruction(read_enable_instruction),
    .empty_data(empty_data),
    .data(data),
    .read_enable_data(read_enable_data),
    .full_result(full_result),
    .result(result),
    .write_enable_result(write_enable_result),
    .full_status(full_status),
    .status(status),
    .write_enable_status(write_enable_status),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ipops = 0;
  int dpops = 0;
  int ipop_cyc = 0;
  int wr_cyc = 0;
  int nwr = 0;
  int split = 0;
  logic [5:0]  iq[$];
  logic [15:0] dq[$];
  logic [31:0] wr_res[$];
  logic [7:0]  wr_st[$];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    empty_instruction = (iq.size() == 0);
    instruction = (iq.size() > 0) ? iq[0] : 6'd0;
    empty_data = (dq.size() == 0);
    data = (dq.size() > 0) ? dq[0] : 16'd0;
  endtask

  task automatic push_i(input logic [1:0] op, input logic [3:0] d);
    iq.push_back({op, d});
    refresh();
  endtask

  task automatic push_d(input logic [15:0] v);
    dq.push_back(v);
    refresh();
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 300 && nwr < n; k++) @(posedge clock);
    check("write_count", nwr, n);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // FIFO pops: enable seen before the edge, head advances after it
  always @(negedge clock) begin
    logic pi, pd;
    pi = read_enable_instruction;
    pd = read_enable_data;
    if (pi) ipop_cyc = cyc;
    if (pi || pd) begin
      @(posedge clock);
      #1;
      if (pi) begin void'(iq.pop_front()); ipops++; end
      if (pd) begin void'(dq.pop_front()); dpops++; end
      refresh();
    end
  end

  always @(negedge clock) begin
    if (write_enable_result || write_enable_status) begin
      if (write_enable_result !== write_enable_status) split++;
      wr_res.push_back(result);
      wr_st.push_back(status);
      wr_cyc = cyc;
      nwr++;
    end
  end

  initial begin
    logic [31:0] exp3;
    int n0, d0, i0;
    reset = 1'b1;
    full_result = 1'b0;
    full_status = 1'b0;
    refresh();
    push_i(2'b00, 4'd2);
    push_d(16'd3); push_d(16'd2); push_d(16'd1); push_d(16'd5);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_re_instr", read_enable_instruction, 0);
    check("rst_re_data", read_enable_data, 0);
    check("rst_we", write_enable_result, 0);
    reset = 1'b0;

    // EVAL deg 2: x=3, 2*9+1*3+5
    wait_wr(1);
    check("t1_result", wr_res[0], 32'd26);
    check("t1_status", wr_st[0], 8'h00);
    check("t1_latency", wr_cyc - ipop_cyc, 6);

    // SUM deg 3
    @(posedge clock); #3;
    push_d(16'd1); push_d(16'd2); push_d(16'd3); push_d(16'd4);
    push_i(2'b01, 4'd3);
    wait_wr(2);
    check("t2_result", wr_res[1], 32'd10);
    check("t2_status", wr_st[1], 8'h01);
    check("t2_latency", wr_cyc - ipop_cyc, 6);

    // NOP: popped, no output, seq unchanged
    @(posedge clock); #3;
    push_i(2'b10, 4'd0);
    repeat (10) @(posedge clock);
    check("nop_writes", nwr, 2);
    check("nop_popped", ipops, 3);
    check("nop_busy", busy, 0);

    // Overflow: x=32767, coefs 32767,0,0,0
    #3;
    push_d(16'd32767); push_d(16'd32767);
    push_d(16'd0); push_d(16'd0); push_d(16'd0);
    push_i(2'b00, 4'd3);
`ifdef SATURATE_EN
    exp3 = 32'h7FFF_FFFF;
`else
    exp3 = 32'h7FFE_0001;
`endif
    wait_wr(3);
    check("t3_result", wr_res[2], exp3);
    check("t3_status", wr_st[2], 8'h82);

    // Illegal opcode and over-degree; data present but untouched
    @(posedge clock); #3;
    push_d(16'd7); push_d(16'hFFFD);
    d0 = dpops;
    push_i(2'b11, 4'd0);
    push_i(2'b00, 4'd15);
    wait_wr(5);
    check("t4a_result", wr_res[3], 0);
    check("t4a_status", wr_st[3], 8'h43);
    check("t4b_result", wr_res[4], 0);
    check("t4b_status", wr_st[4], 8'h44);
    check("t4_latency", wr_cyc - ipop_cyc, 2);
    check("t4_no_data_pop", dpops, d0);
    check("t4_data_left", dq.size(), 2);

    // Back-pressure in WRITE: SUM deg 1 of 7,-3
    @(posedge clock); #3;
    full_result = 1'b1;
    push_i(2'b01, 4'd1);
    for (int k = 0; k < 50 && dq.size() != 0; k++) @(posedge clock);
    check("t5_consumed", dq.size(), 0);
    @(posedge clock); #1;
    n0 = nwr; i0 = ipops; d0 = dpops;
    repeat (5) @(posedge clock);
    #1;
    check("t5_no_push", nwr, n0);
    check("t5_busy", busy, 1);
    check("t5_hold_result", result, 32'd4);
    check("t5_hold_status", status, 8'h05);
    check("t5_no_ipop", ipops, i0);
    check("t5_no_dpop", dpops, d0);
    full_result = 1'b0;
    wait_wr(n0 + 1);
    repeat (5) @(posedge clock);
    check("t5_one_push", nwr, n0 + 1);
    check("t5_result", wr_res[n0], 32'd4);
    check("t5_status", wr_st[n0], 8'h05);

    // Reset after x and two of four coefficients
    #3;
    push_d(16'd2); push_d(16'd1); push_d(16'd1);
    push_d(16'd3); push_d(16'd4);
    d0 = dpops;
    push_i(2'b00, 4'd3);
    for (int k = 0; k < 50; k++) begin
      @(posedge clock); #2;
      if (dpops == d0 + 3) break;
    end
    check("t6_partial", dpops, d0 + 3);
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_busy", busy, 0);
    check("t6_result", result, 0);
    check("t6_status", status, 0);
    check("t6_re_data", read_enable_data, 0);
    reset = 1'b0;
    check("t6_left", dq.size(), 2);
    n0 = nwr;
    push_i(2'b01, 4'd1);
    wait_wr(n0 + 1);
    check("t6_sum", wr_res[n0], 32'd7);
    check("t6_seq0", wr_st[n0], 8'h00);
    check("t6_empty", dq.size(), 0);
    check("split_push", split, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
